// File: rtl/sdram_arb2_if.sv
`timescale 1ns/1ps
// rtl/sdram_arb2_if.sv - requester and Avalon-MM signal bundle for sdram_arb2
interface sdram_arb2_if #(
   parameter int ADDR_W = 32
);
   logic              req0_valid;
   logic              req0_we;
   logic [ADDR_W-1:0] req0_addr;
   logic [15:0]       req0_wdata;
   logic              req0_done;
   logic [15:0]       req0_rdata;
   logic              req0_err;

   logic              req1_valid;
   logic              req1_we;
   logic [ADDR_W-1:0] req1_addr;
   logic [15:0]       req1_wdata;
   logic              req1_done;
   logic [15:0]       req1_rdata;
   logic              req1_err;

   logic [ADDR_W-1:0] address;
   logic [15:0]       writedata;
   logic [1:0]        byteenable;
   logic              chipselect;
   logic              read_n;
   logic              write_n;
   logic              waitrequest;
   logic              readdatavalid;
   logic [15:0]       readdata;

   // arbiter side
   modport master (
      input  req0_valid, req0_we, req0_addr, req0_wdata,
      output req0_done, req0_rdata, req0_err,
      input  req1_valid, req1_we, req1_addr, req1_wdata,
      output req1_done, req1_rdata, req1_err,
      output address, writedata, byteenable, chipselect, read_n, write_n,
      input  waitrequest, readdatavalid, readdata
   );

   // requesters plus SDRAM controller side
   modport slave (
      output req0_valid, req0_we, req0_addr, req0_wdata,
      input  req0_done, req0_rdata, req0_err,
      output req1_valid, req1_we, req1_addr, req1_wdata,
      input  req1_done, req1_rdata, req1_err,
      input  address, writedata, byteenable, chipselect, read_n, write_n,
      output waitrequest, readdatavalid, readdata
   );
endinterface

// File: rtl/sdram_arb2.sv
`timescale 1ns/1ps
// rtl/sdram_arb2.sv - two-requester, one-outstanding arbiter driving an Avalon-MM SDRAM port
// Optional macro SDRAM_ARB_RR_EN: round-robin on ties; undefined gives fixed req0 priority.
module sdram_arb2 #(
   parameter int TIMEOUT = 1024,
   parameter int ADDR_W  = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   sdram_arb2_if.master bus
);
   localparam int               CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CMD    = 2'd1,
      S_RDWAIT = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t            r_state,      w_state;
   logic [ADDR_W-1:0] r_address,    w_address;
   logic [15:0]       r_writedata,  w_writedata;
   logic              r_read_n,     w_read_n;
   logic              r_write_n,    w_write_n;
   logic              r_chipselect, w_chipselect;
   logic              r_we,         w_we;
   logic              r_owner,      w_owner;
   logic [CNT_W-1:0]  r_cnt,        w_cnt;
   logic              r_done0,      w_done0;
   logic              r_done1,      w_done1;
   logic              r_err0,       w_err0;
   logic              r_err1,       w_err1;
   logic [15:0]       r_rdata0,     w_rdata0;
   logic [15:0]       r_rdata1,     w_rdata1;
`ifdef SDRAM_ARB_RR_EN
   logic              r_last_grant, w_last_grant;
`endif

   logic w_pick1;
   logic w_fin;
   logic w_fin_err;

   // next-state and next-output logic; every output is registered so the Avalon side sees clean strobes
   always_comb begin
      w_state      = r_state;
      w_address    = r_address;
      w_writedata  = r_writedata;
      w_read_n     = r_read_n;
      w_write_n    = r_write_n;
      w_chipselect = r_chipselect;
      w_we         = r_we;
      w_owner      = r_owner;
      w_cnt        = r_cnt;
      w_rdata0     = r_rdata0;
      w_rdata1     = r_rdata1;
      w_fin        = 1'b0;
      w_fin_err    = 1'b0;
`ifdef SDRAM_ARB_RR_EN
      w_last_grant = r_last_grant;
      w_pick1      = bus.req1_valid && (!bus.req0_valid || !r_last_grant);
`else
      w_pick1      = bus.req1_valid && !bus.req0_valid;
`endif

      case (r_state)
         S_IDLE: begin
            if (bus.req0_valid || bus.req1_valid) begin
               w_owner      = w_pick1;
               w_we         = w_pick1 ? bus.req1_we    : bus.req0_we;
               w_address    = w_pick1 ? bus.req1_addr  : bus.req0_addr;
               w_writedata  = w_pick1 ? bus.req1_wdata : bus.req0_wdata;
               w_read_n     = w_we;
               w_write_n    = !w_we;
               w_chipselect = 1'b1;
               w_state      = S_CMD;
`ifdef SDRAM_ARB_RR_EN
               w_last_grant = w_pick1;
`endif
            end
         end
         S_CMD: begin
            if (!bus.waitrequest) begin
               w_read_n  = 1'b1;
               w_write_n = 1'b1;
               if (r_we) begin
                  w_chipselect = 1'b0;
                  w_fin        = 1'b1;
                  w_state      = S_DONE;
               end else begin
                  w_cnt   = '0;
                  w_state = S_RDWAIT;
               end
            end
         end
         S_RDWAIT: begin
            w_cnt = r_cnt + CNT_W'(1);
            if (bus.readdatavalid) begin
               if (r_owner) w_rdata1 = bus.readdata;
               else         w_rdata0 = bus.readdata;
               w_fin        = 1'b1;
               w_chipselect = 1'b0;
               w_state      = S_DONE;
            end else if (r_cnt == CNT_LAST) begin
               w_fin        = 1'b1;
               w_fin_err    = 1'b1;
               w_chipselect = 1'b0;
               w_state      = S_DONE;
            end
         end
         S_DONE: begin
            w_state = S_IDLE;
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase

      w_done0 = w_fin && !r_owner;
      w_done1 = w_fin &&  r_owner;
      w_err0  = w_fin_err && !r_owner;
      w_err1  = w_fin_err &&  r_owner;
   end

   // state and output registers; reset drops strobes immediately and abandons any transaction
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_address    <= '0;
         r_writedata  <= '0;
         r_read_n     <= 1'b1;
         r_write_n    <= 1'b1;
         r_chipselect <= 1'b0;
         r_we         <= 1'b0;
         r_owner      <= 1'b0;
         r_cnt        <= '0;
         r_done0      <= 1'b0;
         r_done1      <= 1'b0;
         r_err0       <= 1'b0;
         r_err1       <= 1'b0;
         r_rdata0     <= '0;
         r_rdata1     <= '0;
`ifdef SDRAM_ARB_RR_EN
         r_last_grant <= 1'b1;
`endif
      end else begin
         r_state      <= w_state;
         r_address    <= w_address;
         r_writedata  <= w_writedata;
         r_read_n     <= w_read_n;
         r_write_n    <= w_write_n;
         r_chipselect <= w_chipselect;
         r_we         <= w_we;
         r_owner      <= w_owner;
         r_cnt        <= w_cnt;
         r_done0      <= w_done0;
         r_done1      <= w_done1;
         r_err0       <= w_err0;
         r_err1       <= w_err1;
         r_rdata0     <= w_rdata0;
         r_rdata1     <= w_rdata1;
`ifdef SDRAM_ARB_RR_EN
         r_last_grant <= w_last_grant;
`endif
      end
   end

   assign bus.address    = r_address;
   assign bus.writedata  = r_writedata;
   assign bus.byteenable = 2'b11;
   assign bus.chipselect = r_chipselect;
   assign bus.read_n     = r_read_n;
   assign bus.write_n    = r_write_n;
   assign bus.req0_done  = r_done0;
   assign bus.req1_done  = r_done1;
   assign bus.req0_err   = r_err0;
   assign bus.req1_err   = r_err1;
   assign bus.req0_rdata = r_rdata0;
   assign bus.req1_rdata = r_rdata1;
endmodule

// File: tb/tb_sdram_arb2.sv
`timescale 1ns/1ps
// tb/tb_sdram_arb2.sv - scoreboard bench for sdram_arb2 with an SDRAM slave model
module tb_sdram_arb2;
   localparam int TO = 8;
   localparam int AW = 32;
   localparam int K  = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sdram_arb2_if #(.ADDR_W(AW)) bus();

   sdram_arb2 #(.TIMEOUT(TO), .ADDR_W(AW)) dut (
      .clk     (clk),
      .reset_n (rst_n),
      .bus     (bus.master)
   );

   typedef struct packed {
      logic        we;
      logic        err;
      logic [15:0] rdata;
   } rsp_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [15:0] wdata;
   } acc_t;

   rsp_t rsp_q0[$];
   rsp_t rsp_q1[$];
   acc_t acc_q0[$];
   acc_t acc_q1[$];
   int   grant_log[$];

   int total = 0;
   int bad   = 0;

   logic [15:0] ref_mem [64];
   logic [15:0] slv_mem [64];
   logic [15:0] exp_last [2];

   // slave model configuration
   logic        rnd_mode  = 1'b0;
   logic        force_wait = 1'b0;
   logic        no_rsp    = 1'b0;
   int          cfg_stall = 0;
   int          cfg_lat   = 1;
   logic        in_cmd    = 1'b0;
   int          stall_cnt = 0;
   int          cur_stall = 0;
   logic        rdv_pend  = 1'b0;
   int          rdv_delay = 0;
   logic [15:0] rdv_data  = '0;

   // monitor state
   rsp_t        m_r;
   acc_t        m_a;
   logic [49:0] snap;
   logic        prev_stall = 1'b0;
   logic        strobe;
   int          cur_len  = 0;
   int          last_len = 0;
   int          gid;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      if (n > 0) begin
         repeat (n) @(posedge clk);
         #1;
      end
   endtask

   // issue one request from requester n, queue its expectations, wait for done
   task automatic issue(input int n, input logic we, input logic [4:0] lo, input logic [15:0] wd,
                        input logic exp_err, input logic hold, input logic rnd_hi, output int lat);
      logic [31:0] a;
      acc_t        ac;
      rsp_t        rs;
      logic        d;
      a = rnd_hi ? $urandom : 32'h0;
      a[5]   = n[0];
      a[4:0] = lo;
      ac.we = we; ac.addr = a; ac.wdata = wd;
      rs.we = we; rs.err = exp_err;
      if (we) begin
         ref_mem[a[5:0]] = wd;
         rs.rdata = exp_last[n];
      end else if (exp_err) begin
         rs.rdata = exp_last[n];
      end else begin
         rs.rdata    = ref_mem[a[5:0]];
         exp_last[n] = rs.rdata;
      end
      if (n == 0) begin
         acc_q0.push_back(ac); rsp_q0.push_back(rs);
         bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = wd; bus.req0_valid = 1'b1;
      end else begin
         acc_q1.push_back(ac); rsp_q1.push_back(rs);
         bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = wd; bus.req1_valid = 1'b1;
      end
      lat = 0;
      d   = 1'b0;
      while (!d && lat < 300) begin
         @(negedge clk);
         lat++;
         d = (n == 0) ? bus.req0_done : bus.req1_done;
      end
      if (!d) begin
         total++; bad++;
         $display("FAIL done_wait%0d: no done after %0d cycles, required a done pulse", n, lat);
      end
      @(posedge clk); #1;
      if (!hold) begin
         if (n == 0) bus.req0_valid = 1'b0;
         else        bus.req1_valid = 1'b0;
      end
   endtask

   // SDRAM controller model: stalls, memory, delayed readdatavalid
   initial begin
      bus.waitrequest   = 1'b0;
      bus.readdatavalid = 1'b0;
      bus.readdata      = '0;
      forever begin
         @(posedge clk); #1;
         bus.readdatavalid = 1'b0;
         bus.readdata      = 16'($urandom);
         if (!rst_n) begin
            in_cmd = 1'b0; rdv_pend = 1'b0; bus.waitrequest = 1'b0;
         end else begin
            if (rdv_pend) begin
               if (rdv_delay == 0) begin
                  bus.readdatavalid = 1'b1;
                  bus.readdata      = rdv_data;
                  rdv_pend          = 1'b0;
               end else begin
                  rdv_delay--;
               end
            end
            if (bus.chipselect && (!bus.read_n || !bus.write_n)) begin
               if (!in_cmd) begin
                  in_cmd    = 1'b1;
                  stall_cnt = 0;
                  cur_stall = rnd_mode ? int'($urandom_range(0, 2)) : cfg_stall;
               end
               if (force_wait || stall_cnt < cur_stall) begin
                  bus.waitrequest = 1'b1;
                  stall_cnt++;
               end else begin
                  bus.waitrequest = 1'b0;
                  in_cmd = 1'b0;
                  if (!bus.write_n) begin
                     slv_mem[bus.address[5:0]] = bus.writedata;
                  end else if (!no_rsp) begin
                     rdv_pend  = 1'b1;
                     rdv_delay = (rnd_mode ? int'($urandom_range(1, 3)) : cfg_lat) - 1;
                     rdv_data  = slv_mem[bus.address[5:0]];
                  end
               end
            end else begin
               in_cmd = 1'b0;
               bus.waitrequest = 1'($urandom);
            end
         end
      end
   end

   // bus and completion monitor
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
         cur_len    = 0;
      end else begin
         strobe = !bus.read_n || !bus.write_n;
         if (prev_stall)
            check("stable_cmd", 64'({bus.address, bus.writedata, bus.read_n, bus.write_n}), 64'(snap));
         if (strobe) begin
            check("cs_with_strobe", 64'(bus.chipselect), 64'd1);
            cur_len++;
         end else if (cur_len != 0) begin
            last_len = cur_len;
            cur_len  = 0;
         end
         if (strobe && bus.chipselect && !bus.waitrequest) begin
            gid = int'(bus.address[5]);
            grant_log.push_back(gid);
            check("byteenable", 64'(bus.byteenable), 64'd3);
            check("one_strobe", 64'(bus.read_n ^ bus.write_n), 64'd1);
            if ((gid == 0 && acc_q0.size() == 0) || (gid == 1 && acc_q1.size() == 0)) begin
               total++; bad++;
               $display("FAIL spurious_access: got access to %0h, required none", bus.address);
            end else begin
               m_a = (gid == 0) ? acc_q0.pop_front() : acc_q1.pop_front();
               check("acc_we", 64'(!bus.write_n), 64'(m_a.we));
               check("acc_addr", 64'(bus.address), 64'(m_a.addr));
               if (m_a.we) check("acc_wdata", 64'(bus.writedata), 64'(m_a.wdata));
            end
         end
         prev_stall = strobe && bus.waitrequest;
         snap       = {bus.address, bus.writedata, bus.read_n, bus.write_n};

         if (bus.req0_done && bus.req1_done) begin
            total++; bad++;
            $display("FAIL both_done: got two done pulses, required one");
         end
         if (bus.req0_done) begin
            if (rsp_q0.size() == 0) begin
               total++; bad++;
               $display("FAIL spurious_done0: got done, required none");
            end else begin
               m_r = rsp_q0.pop_front();
               check("done0_err", 64'(bus.req0_err), 64'(m_r.err));
               check("done0_rdata", 64'(bus.req0_rdata), 64'(m_r.rdata));
            end
         end
         if (bus.req1_done) begin
            if (rsp_q1.size() == 0) begin
               total++; bad++;
               $display("FAIL spurious_done1: got done, required none");
            end else begin
               m_r = rsp_q1.pop_front();
               check("done1_err", 64'(bus.req1_err), 64'(m_r.err));
               check("done1_rdata", 64'(bus.req1_rdata), 64'(m_r.rdata));
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   int lat, l0, l1, w, exp_g;
   logic [15:0] v;

   initial begin
      for (int i = 0; i < 64; i++) begin
         v = 16'($urandom);
         ref_mem[i] = v;
         slv_mem[i] = v;
      end
      ref_mem[32] = 16'h1234;
      slv_mem[32] = 16'h1234;
      exp_last[0] = '0;
      exp_last[1] = '0;
      bus.req0_valid = 0; bus.req0_we = 0; bus.req0_addr = '0; bus.req0_wdata = '0;
      bus.req1_valid = 0; bus.req1_we = 0; bus.req1_addr = '0; bus.req1_wdata = '0;

      rst_n = 1'b0;
      tick(3);
      check("rst_read_n",  64'(bus.read_n), 64'd1);
      check("rst_write_n", 64'(bus.write_n), 64'd1);
      check("rst_cs",      64'(bus.chipselect), 64'd0);
      check("rst_addr",    64'(bus.address), 64'd0);
      check("rst_wdata",   64'(bus.writedata), 64'd0);
      check("rst_done",    64'({bus.req0_done, bus.req1_done, bus.req0_err, bus.req1_err}), 64'd0);
      check("rst_rdata",   64'({bus.req0_rdata, bus.req1_rdata}), 64'd0);
      rst_n = 1'b1;
      tick(1);

      // single write, no stall
      cfg_stall = 0; cfg_lat = 1;
      issue(0, 1'b1, 5'h10, 16'hBEEF, 1'b0, 1'b0, 1'b0, lat);
      check("wr_latency", 64'(lat), 64'd3);
      check("wr_strobe_len", 64'(last_len), 64'd1);

      // read with 4 stall cycles, data two cycles after acceptance
      cfg_stall = 4; cfg_lat = 2;
      issue(1, 1'b0, 5'h00, 16'h0, 1'b0, 1'b0, 1'b0, lat);
      check("rd_latency", 64'(lat), 64'd9);
      check("rd_strobe_len", 64'(last_len), 64'd5);
      check("rd_data", 64'(bus.req1_rdata), 64'h1234);

      // read timeout, then a late readdatavalid that must be ignored
      cfg_stall = 0; cfg_lat = 1; no_rsp = 1'b1;
      issue(0, 1'b0, 5'h03, 16'h0, 1'b1, 1'b0, 1'b1, lat);
      check("to_latency", 64'(lat), 64'(TO + 3));
      no_rsp = 1'b0;
      rdv_data = 16'hDEAD; rdv_delay = 1; rdv_pend = 1'b1;
      tick(5);
      check("late_rdv_ignored", 64'(bus.req0_rdata), 64'(exp_last[0]));

      // reset while a read is stalled in CMD
      force_wait = 1'b1;
      bus.req0_we = 1'b0; bus.req0_addr = 32'h5; bus.req0_valid = 1'b1;
      w = 0;
      while (bus.read_n && w < 10) begin @(negedge clk); w++; end
      check("rst_cmd_reached", 64'(bus.read_n), 64'd0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_read_n", 64'(bus.read_n), 64'd1);
      check("rst_mid_cs", 64'(bus.chipselect), 64'd0);
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      force_wait = 1'b0;
      tick(2);
      rst_n = 1'b1;
      exp_last[0] = '0;
      exp_last[1] = '0;
      tick(6);
      issue(0, 1'b1, 5'h09, 16'h5A5A, 1'b0, 1'b0, 1'b1, lat);
      check("post_rst_latency", 64'(lat), 64'd3);

      // back-to-back on one requester
      issue(0, 1'b1, 5'h07, 16'hA5A5, 1'b0, 1'b0, 1'b1, lat);
      issue(0, 1'b0, 5'h07, 16'h0, 1'b0, 1'b0, 1'b1, lat);
      check("b2b_no_extra_access", 64'(acc_q0.size()), 64'd0);

      // contention: req1 granted last, then both hold valid continuously
      issue(1, 1'b1, 5'h01, 16'h0F0F, 1'b0, 1'b0, 1'b1, lat);
      grant_log.delete();
      fork
         begin
            for (int i = 0; i < K; i++)
               issue(0, 1'($urandom), 5'($urandom), 16'($urandom), 1'b0, 1'(i < K - 1), 1'b1, l0);
         end
         begin
            for (int j = 0; j < K; j++)
               issue(1, 1'($urandom), 5'($urandom), 16'($urandom), 1'b0, 1'(j < K - 1), 1'b1, l1);
         end
      join
      check("grant_count", 64'(grant_log.size()), 64'(2 * K));
      for (int i = 0; i < 2 * K; i++) begin
`ifdef SDRAM_ARB_RR_EN
         exp_g = i % 2;
`else
         exp_g = (i < K) ? 0 : 1;
`endif
         if (i < grant_log.size()) check("grant_order", 64'(grant_log[i]), 64'(exp_g));
      end

      // randomized traffic on both ports
      rnd_mode = 1'b1;
      fork
         begin
            for (int i = 0; i < 20; i++) begin
               tick(int'($urandom_range(0, 2)));
               issue(0, 1'($urandom), 5'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1, l0);
            end
         end
         begin
            for (int j = 0; j < 20; j++) begin
               tick(int'($urandom_range(0, 2)));
               issue(1, 1'($urandom), 5'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1, l1);
            end
         end
      join
      rnd_mode = 1'b0;
      tick(5);
      check("end_rsp_q0", 64'(rsp_q0.size()), 64'd0);
      check("end_rsp_q1", 64'(rsp_q1.size()), 64'd0);
      check("end_acc_q0", 64'(acc_q0.size()), 64'd0);
      check("end_acc_q1", 64'(acc_q1.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sdram_arb2.md
Name: sdram_arb2

Overview:
Two-port arbiter that shares the single 16-bit Avalon-MM SDRAM master port between two requesters, e.g. a frame reader and a result writer. Each requester issues one single-word read or write at a time using a valid/done handshake. The arbiter serialises accesses: one transaction outstanding at a time, selected by round-robin or fixed priority. It drives the SDRAM controller's slave interface directly.

Parameters:
TIMEOUT, 1024, max cycles to wait in RDWAIT for readdatavalid before aborting with error
ADDR_W, 32, address width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 command pending
req0_we  in  1  1=write, 0=read
req0_addr  in  ADDR_W  word address
req0_wdata  in  16  write data
req0_done  out  1  one-cycle completion pulse
req0_rdata  out  16  read data, valid when req0_done and !req0_we
req0_err  out  1  qualifies req0_done; read timed out
req1_valid, req1_we, req1_addr, req1_wdata, req1_done, req1_rdata, req1_err  same as requester 0
address  out  ADDR_W  Avalon address
writedata  out  16  Avalon write data
byteenable  out  2  constant 2'b11
chipselect  out  1  high in CMD and RDWAIT
read_n  out  1  active-low read strobe
write_n  out  1  active-low write strobe
waitrequest  in  1  Avalon stall
readdatavalid  in  1  Avalon read data valid
readdata  in  16  Avalon read data

Behaviour:
- Reset (async, reset_n=0): state=IDLE, read_n=1, write_n=1, chipselect=0, address=0, writedata=0, all done/err=0, rdata=0, timeout counter=0, last_grant=1 (so req0 wins the first tie).
- IDLE: if any reqN_valid, pick owner: one valid -> that one; both valid -> the one != last_grant. Latch addr/wdata/we into address/writedata. Next cycle: CMD, with read_n=0 (we=0) or write_n=0 (we=1) and chipselect=1. last_grant <= owner.
- CMD: hold address/writedata/strobe stable while waitrequest=1. On waitrequest=0, deassert the strobe next cycle. Write: go to DONE. Read: go to RDWAIT, counter cleared.
- RDWAIT: strobes high, counter increments. On readdatavalid=1, capture readdata into owner's rdata and go to DONE. If readdatavalid and counter==TIMEOUT in the same cycle, data wins. If counter reaches TIMEOUT without data: go to DONE with err=1; rdata unchanged.
- DONE: owner's done=1 for exactly one cycle (err per above), chipselect=0, return to IDLE. A new grant is possible in the next cycle.
- Minimum write latency, valid to done: 3 cycles with waitrequest=0. Minimum read latency: 3 cycles plus read latency.
- Requester must hold valid and fields stable until its done pulse, then drop valid in the cycle after done. Valid still high in IDLE is treated as a new request.
- Non-owner's valid is ignored until IDLE. Deasserting the owner's valid mid-transaction does not abort it.
- Late readdatavalid after a timeout abort is ignored.
- reset_n asserted mid-transaction: immediate return to IDLE with strobes high. No done is issued.

Optional Feature:
SDRAM_ARB_RR_EN. Defined: round-robin on ties as described above. Undefined: fixed priority, req0 always wins ties, and last_grant is not implemented. Req1 can then starve; this is acceptable for writer-only ports.

Test Plan:
- Single write: req0 we=1, addr=0x10, wdata=0xBEEF, waitrequest=0 -> write_n low 1 cycle, address=0x10, writedata=0xBEEF, req0_done pulses 3 cycles after valid, err=0.
- Read with stall: req1 read addr=0x20, waitrequest high 4 cycles, readdata=0x1234 two cycles after acceptance -> read_n held low 5 cycles with stable address, req1_rdata=0x1234, req1_done single pulse.
- Contention: both valid continuously with done-driven re-requests -> grants alternate 0,1,0,1 (RR). With macro undefined, req0 gets every grant.
- Timeout: TIMEOUT=8, read accepted, no readdatavalid -> req0_done with req0_err=1 after 8 RDWAIT cycles. A later readdatavalid is ignored and rdata is unchanged.
- Reset mid-CMD: reset_n low while read_n=0 and waitrequest=1 -> read_n=1, chipselect=0 immediately. No done pulse after release. Next request proceeds normally.
- Back-to-back same requester: req0 drops valid for 1 cycle after done, then reasserts -> second command issued, with no spurious duplicate access.
